// File: rtl/hls_call_ctrl_if.sv
// rtl/hls_call_ctrl_if.sv - argument/result streams, callee handshake and status of hls_call_ctrl
interface hls_call_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_timeout;
  logic [CNT_W-1:0]  out_latency;

  logic [DATA_W-1:0] call_a;
  logic [DATA_W-1:0] call_b;
  logic              call_start;
  logic              call_idle;
  logic              call_done;
  logic [DATA_W-1:0] call_ret;

  logic              busy;
  logic [CNT_W-1:0]  ok_count;
  logic [CNT_W-1:0]  to_count;

  // master is the controller, slave is the host fabric plus callee around it
  modport master (
    input  in_valid, in_a, in_b, out_ready, call_idle, call_done, call_ret,
    output in_ready, out_valid, out_result, out_timeout, out_latency,
           call_a, call_b, call_start, busy, ok_count, to_count
  );

  modport slave (
    output in_valid, in_a, in_b, out_ready, call_idle, call_done, call_ret,
    input  in_ready, out_valid, out_result, out_timeout, out_latency,
           call_a, call_b, call_start, busy, ok_count, to_count
  );
endinterface

// File: rtl/hls_call_ctrl.sv
// rtl/hls_call_ctrl.sv - caller-side start/idle/done controller with watchdog and call statistics
module hls_call_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input logic           sys_clk,
  input logic           sys_rst,
  hls_call_ctrl_if.master bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_LAT  = CNT_W'(TIMEOUT);

  logic [1:0]        state_q,       state_d;
  logic [DATA_W-1:0] call_a_q,      call_a_d;
  logic [DATA_W-1:0] call_b_q,      call_b_d;
  logic [DATA_W-1:0] out_result_q,  out_result_d;
  logic              out_timeout_q, out_timeout_d;
  logic [CNT_W-1:0]  out_latency_q, out_latency_d;
  logic [CNT_W-1:0]  timer_q,       timer_d;
  logic [CNT_W-1:0]  ok_q,          ok_d;
  logic [CNT_W-1:0]  to_q,          to_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d       = state_q;
    call_a_d      = call_a_q;
    call_b_d      = call_b_q;
    out_result_d  = out_result_q;
    out_timeout_d = out_timeout_q;
    out_latency_d = out_latency_q;
    timer_d       = timer_q;
    ok_d          = ok_q;
    to_d          = to_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          call_a_d = bus.in_a;
          call_b_d = bus.in_b;
          state_d  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (bus.call_idle) begin
          timer_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        timer_d = sat_inc(timer_q);
        // a done arriving on the last allowed cycle still counts as success
        if (bus.call_done) begin
          out_result_d  = bus.call_ret;
          out_timeout_d = 1'b0;
          out_latency_d = sat_inc(timer_q);
          ok_d          = sat_inc(ok_q);
          state_d       = S_RESULT;
        end else if (timer_q == TO_LAST) begin
          out_result_d  = '0;
          out_timeout_d = 1'b1;
          out_latency_d = TO_LAT;
          to_d          = sat_inc(to_q);
          state_d       = S_RESULT;
        end
      end
      default: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= S_IDLE;
      call_a_q      <= '0;
      call_b_q      <= '0;
      out_result_q  <= '0;
      out_timeout_q <= 1'b0;
      out_latency_q <= '0;
      timer_q       <= '0;
      ok_q          <= '0;
      to_q          <= '0;
    end else begin
      state_q       <= state_d;
      call_a_q      <= call_a_d;
      call_b_q      <= call_b_d;
      out_result_q  <= out_result_d;
      out_timeout_q <= out_timeout_d;
      out_latency_q <= out_latency_d;
      timer_q       <= timer_d;
      ok_q          <= ok_d;
      to_q          <= to_d;
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.call_start  = (state_q == S_LAUNCH) && bus.call_idle;
  assign bus.out_valid   = (state_q == S_RESULT);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.call_a      = call_a_q;
  assign bus.call_b      = call_b_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_timeout = out_timeout_q;
  assign bus.out_latency = out_latency_q;
  assign bus.ok_count    = ok_q;
  assign bus.to_count    = to_q;

endmodule

// File: tb/tb_hls_call_ctrl.sv
// tb/tb_hls_call_ctrl.sv - directed self-checking bench for hls_call_ctrl with a gcd callee model
module tb_hls_call_ctrl;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int TO = 16;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;

  hls_call_ctrl_if #(.DATA_W(DW), .CNT_W(CW)) bus();

  hls_call_ctrl #(.DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int errors    = 0;
  int checks    = 0;
  int cycle     = 0;
  int start_cnt = 0;
  int cal_cnt   = 0;
  int cal_lat   = 5;
  bit cal_en    = 1'b1;
  int acc_cycle = 0;
  int s0        = 0;
  logic [DW-1:0] gcd_res = '0;

  function automatic logic [DW-1:0] ref_gcd(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one clock; callee model answers call_start with done cal_lat cycles later
  task automatic tick();
    logic st;
    logic [DW-1:0] a, b;
    st = bus.call_start;
    a  = bus.call_a;
    b  = bus.call_b;
    @(posedge sys_clk);
    #1;
    cycle++;
    bus.call_done = 1'b0;
    if (cal_cnt > 0) begin
      cal_cnt--;
      if (cal_cnt == 0) begin
        bus.call_done = 1'b1;
        bus.call_ret  = gcd_res;
      end
    end
    if (st) begin
      start_cnt++;
      if (cal_en) begin
        cal_cnt = cal_lat - 1;
        gcd_res = ref_gcd(a, b);
      end
    end
    #1;
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b);
    check("in_ready_before_send", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    acc_cycle    = cycle;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int max);
    int n;
    n = 0;
    while (!bus.out_valid && n < max) begin
      tick();
      n++;
    end
    if (!bus.out_valid) check("out_valid_wait_expired", 0, 1);
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("out_valid_after_ready", bus.out_valid, 0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    bus.call_idle = 1'b1;
    bus.call_done = 1'b0;
    bus.call_ret  = '0;

    repeat (3) tick();
    sys_rst = 1'b0;
    check("rst_in_ready",    bus.in_ready, 1);
    check("rst_out_valid",   bus.out_valid, 0);
    check("rst_busy",        bus.busy, 0);
    check("rst_call_start",  bus.call_start, 0);
    check("rst_out_result",  bus.out_result, 0);
    check("rst_out_latency", bus.out_latency, 0);
    check("rst_call_a",      bus.call_a, 0);
    check("rst_ok_count",    bus.ok_count, 0);
    check("rst_to_count",    bus.to_count, 0);

    // basic gcd call, 5-cycle callee
    s0 = start_cnt;
    send(48, 18);
    check("t1_call_start", bus.call_start, 1);
    wait_out(40);
    check("t1_result",     bus.out_result, 6);
    check("t1_timeout",    bus.out_timeout, 0);
    check("t1_latency",    bus.out_latency, 5);
    check("t1_ok_count",   bus.ok_count, 1);
    check("t1_starts",     start_cnt - s0, 1);
    check("t1_in_to_out",  cycle - acc_cycle, 7);
    check("t1_in_ready",   bus.in_ready, 0);
    release_out();
    check("t1_idle_ready", bus.in_ready, 1);

    // callee busy for 4 cycles after accept
    bus.call_idle = 1'b0;
    s0 = start_cnt;
    send(48, 18);
    for (int i = 0; i < 4; i++) begin
      check("t2_no_start", bus.call_start, 0);
      check("t2_call_a",   bus.call_a, 48);
      check("t2_call_b",   bus.call_b, 18);
      tick();
    end
    bus.call_idle = 1'b1;
    #1;
    check("t2_start_on_idle", bus.call_start, 1);
    wait_out(40);
    check("t2_result",   bus.out_result, 6);
    check("t2_starts",   start_cnt - s0, 1);
    check("t2_call_a_h", bus.call_a, 48);
    check("t2_call_b_h", bus.call_b, 18);
    check("t2_ok_count", bus.ok_count, 2);
    release_out();

    // callee never answers: watchdog fires
    cal_en = 1'b0;
    send(7, 3);
    wait_out(40);
    check("t3_timeout",  bus.out_timeout, 1);
    check("t3_result",   bus.out_result, 0);
    check("t3_latency",  bus.out_latency, TO);
    check("t3_to_count", bus.to_count, 1);
    check("t3_ok_count", bus.ok_count, 2);
    release_out();
    bus.call_ret  = 32'd99;
    bus.call_done = 1'b1;
    tick();
    check("t3_late_ok",  bus.ok_count, 2);
    check("t3_late_to",  bus.to_count, 1);
    check("t3_late_busy", bus.busy, 0);
    cal_en = 1'b1;
    send(12, 8);
    wait_out(40);
    check("t3_next_result",  bus.out_result, 4);
    check("t3_next_timeout", bus.out_timeout, 0);
    check("t3_next_ok",      bus.ok_count, 3);
    release_out();

    // done lands exactly on the last watchdog cycle
    cal_lat = TO;
    send(9, 6);
    wait_out(40);
    check("t4_timeout",  bus.out_timeout, 0);
    check("t4_result",   bus.out_result, 3);
    check("t4_latency",  bus.out_latency, TO);
    check("t4_ok_count", bus.ok_count, 4);
    check("t4_to_count", bus.to_count, 1);
    release_out();

    // consumer stalls while a new pair is offered
    cal_lat = 3;
    send(100, 75);
    wait_out(40);
    bus.in_valid = 1'b1;
    bus.in_a     = 35;
    bus.in_b     = 21;
    for (int i = 0; i < 10; i++) begin
      check("t5_in_ready", bus.in_ready, 0);
      check("t5_valid",    bus.out_valid, 1);
      check("t5_result",   bus.out_result, 25);
      check("t5_latency",  bus.out_latency, 3);
      tick();
    end
    release_out();
    send(35, 21);
    wait_out(40);
    check("t5_next_result", bus.out_result, 7);
    check("t5_ok_count",    bus.ok_count, 6);
    release_out();

    // reset in the middle of a call, callee left running
    cal_lat = 10;
    send(20, 5);
    repeat (3) tick();
    check("t6_busy_pre", bus.busy, 1);
    sys_rst = 1'b1;
    tick();
    cal_cnt = 0;
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_busy",      bus.busy, 0);
    check("t6_in_ready",  bus.in_ready, 1);
    check("t6_ok_count",  bus.ok_count, 0);
    check("t6_to_count",  bus.to_count, 0);
    check("t6_call_a",    bus.call_a, 0);
    check("t6_result",    bus.out_result, 0);
    check("t6_start",     bus.call_start, 0);
    sys_rst = 1'b0;
    bus.call_idle = 1'b0;
    cal_lat = 5;
    send(30, 12);
    for (int i = 0; i < 3; i++) begin
      check("t6_wait_launch", bus.call_start, 0);
      check("t6_busy_launch", bus.busy, 1);
      tick();
    end
    bus.call_idle = 1'b1;
    #1;
    check("t6_start_on_idle", bus.call_start, 1);
    wait_out(40);
    check("t6_next_result", bus.out_result, 6);
    check("t6_next_ok",     bus.ok_count, 1);
    release_out();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
